// File: rtl/spi_slave_param.sv
// SPI slave front-end: MOSI frames {cmd, payload} -> rx_data/rx_valid, RAM read data -> MISO.
// Define SPI_TX_TIMEOUT_EN to abandon a read after TIMEOUT_CYC cycles without tx_valid (rd_timeout pulse).

// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | SS_n high or frame just started; nothing in flight
// CHK_CMD   | sample mode bit, pick WRITE / READ_ADD / READ_DATA
// WRITE     | shift in write frame
// READ_ADD  | shift in read-address frame
// READ_DATA | shift in read-data frame, then wait for tx_valid (rd_wait)
// TX        | serialise latched tx_data on MISO, MSB first
// DONE      | frame finished, hold MISO low until SS_n rises

module spi_slave_param #(
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MOSI,
    input  logic              SS_n,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              rd_timeout
);

    localparam int FRAME_W = DATA_W + 2;
    localparam int CNT_W   = $clog2(FRAME_W);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("spi_slave_param: TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA,
        TX,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-2:0] shift_reg;
    logic [DATA_W-1:0]  tx_shift;
    logic               rd_addr_done;
    logic               rd_wait;
    logic               shifting;
    logic               cnt_zero;
    logic               timeout_hit;

    assign cnt_zero = (bit_cnt == '0);
    // READ_DATA keeps its state while waiting for the RAM; rd_wait separates that from shifting.
    assign shifting = (state == WRITE) || (state == READ_ADD) ||
                      ((state == READ_DATA) && !rd_wait);

`ifdef SPI_TX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt;

    assign timeout_hit = (state == READ_DATA) && rd_wait && !tx_valid && (to_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt     <= '0;
            rd_timeout <= 1'b0;
        end else begin
            rd_timeout <= timeout_hit && !SS_n;
            if ((state == READ_DATA) && shifting && cnt_zero) begin
                to_cnt <= TO_W'(TIMEOUT_CYC - 1);
            end else if (rd_wait && (to_cnt != '0)) begin
                to_cnt <= to_cnt - TO_W'(1);
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rd_timeout  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (SS_n) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = CHK_CMD;
                CHK_CMD: begin
                    if (!MOSI) begin
                        state_nxt = WRITE;
                    end else if (rd_addr_done) begin
                        state_nxt = READ_DATA;
                    end else begin
                        state_nxt = READ_ADD;
                    end
                end
                WRITE, READ_ADD: begin
                    if (cnt_zero) begin
                        state_nxt = DONE;
                    end
                end
                READ_DATA: begin
                    if (rd_wait) begin
                        if (tx_valid) begin
                            state_nxt = TX;
                        end else if (timeout_hit) begin
                            state_nxt = DONE;
                        end
                    end
                end
                TX: begin
                    if (cnt_zero) begin
                        state_nxt = DONE;
                    end
                end
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        MISO = 1'b0;
        if (state == TX) begin
            MISO = tx_shift[DATA_W-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt      <= '0;
            shift_reg    <= '0;
            tx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rd_addr_done <= 1'b0;
            rd_wait      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (SS_n) begin
                bit_cnt <= '0;
                rd_wait <= 1'b0;
            end else begin
                case (state)
                    CHK_CMD: begin
                        bit_cnt <= CNT_W'(FRAME_W - 1);
                        rd_wait <= 1'b0;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (shifting) begin
                            shift_reg <= {shift_reg[FRAME_W-3:0], MOSI};
                            if (cnt_zero) begin
                                rx_data  <= {shift_reg, MOSI};
                                rx_valid <= 1'b1;
                                if (state == READ_ADD) begin
                                    rd_addr_done <= 1'b1;
                                end
                                if (state == READ_DATA) begin
                                    rd_addr_done <= 1'b0;
                                    rd_wait      <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt - CNT_W'(1);
                            end
                        end else if (tx_valid) begin
                            tx_shift <= tx_data;
                            bit_cnt  <= CNT_W'(DATA_W - 1);
                            rd_wait  <= 1'b0;
                        end else if (timeout_hit) begin
                            rd_wait <= 1'b0;
                        end
                    end
                    TX: begin
                        tx_shift <= tx_shift << 1;
                        if (!cnt_zero) begin
                            bit_cnt <= bit_cnt - CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: 8-bit instance driven from a vector table with an rx scoreboard,
// plus hand sequences for abort, reset, tx wait and a 16-bit instance.
`timescale 1ns/1ps

module tb_spi_slave_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mosi;
    logic        ss8;
    logic        ss16;
    logic        tx_valid;
    logic [7:0]  tx8;
    logic [15:0] tx16;
    logic        miso8;
    logic [9:0]  rx_data8;
    logic        rx_valid8;
    logic        rd_to8;
    logic        miso16;
    logic [17:0] rx_data16;
    logic        rx_valid16;
    logic        rd_to16;

    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    spi_slave_param #(.DATA_W(8), .TIMEOUT_CYC(64)) dut8 (
        .clk(clk), .rst_n(rst_n), .MOSI(mosi), .SS_n(ss8), .MISO(miso8),
        .rx_data(rx_data8), .rx_valid(rx_valid8), .tx_data(tx8),
        .tx_valid(tx_valid), .rd_timeout(rd_to8)
    );

    spi_slave_param #(.DATA_W(16), .TIMEOUT_CYC(64)) dut16 (
        .clk(clk), .rst_n(rst_n), .MOSI(mosi), .SS_n(ss16), .MISO(miso16),
        .rx_data(rx_data16), .rx_valid(rx_valid16), .tx_data(tx16),
        .tx_valid(tx_valid), .rd_timeout(rd_to16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive select low, the mode bit, then nbits of the frame MSB first.
    task automatic send(input logic mode, input logic [17:0] frame, input int fw,
                        input int nbits, input bit wide);
        if (wide) ss16 = 1'b0; else ss8 = 1'b0;
        if (!wide && nbits == fw) exp_q.push_back(frame[9:0]);
        step();
        mosi = mode;
        step();
        for (int i = fw - 1; i >= fw - nbits; i--) begin
            mosi = frame[i];
            step();
        end
        mosi = 1'b0;
    endtask

    task automatic deselect();
        ss8  = 1'b1;
        ss16 = 1'b1;
        step();
    endtask

    task automatic expect_tx8(input logic [7:0] b, input string name);
        for (int k = 7; k >= 0; k--) begin
            check(name, 32'(miso8), 32'(b[k]));
            step();
        end
        check({name, "_end"}, 32'(miso8), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rx_valid8 === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rx_strobe: got rx_valid with rx_data 0x%0h, expected no strobe", rx_data8);
            end else begin
                check("rx_data_sb", 32'(rx_data8), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    typedef struct {
        logic       mode;
        logic [9:0] frame;
        int         tx_delay;   // -1: no read response expected
        logic [7:0] tx_byte;
        logic       exp_addr_done;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic seen_m;
        logic seen_t;

        vecs[0] = '{1'b0, 10'h0A5, -1, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 10'h13C, -1, 8'h00, 1'b0};
        vecs[2] = '{1'b1, 10'h212, -1, 8'h00, 1'b1};
        vecs[3] = '{1'b1, 10'h300,  0, 8'hC3, 1'b0};
        vecs[4] = '{1'b1, 10'h2A7, -1, 8'h00, 1'b1};
        vecs[5] = '{1'b1, 10'h35A,  3, 8'h5A, 1'b0};
        vecs[6] = '{1'b0, 10'h0FF, -1, 8'h00, 1'b0};
        vecs[7] = '{1'b1, 10'h281, -1, 8'h00, 1'b1};
        vecs[8] = '{1'b0, 10'h042, -1, 8'h00, 1'b1};
        vecs[9] = '{1'b1, 10'h3E1,  1, 8'h96, 1'b0};

        // reset with select active and MOSI high
        rst_n = 1'b0; ss8 = 1'b0; ss16 = 1'b0; mosi = 1'b1;
        tx_valid = 1'b0; tx8 = 8'h00; tx16 = 16'h0000;
        step();
        check("rst_miso", 32'(miso8), 32'd0);
        check("rst_rx_valid", 32'(rx_valid8), 32'd0);
        check("rst_rx_data", 32'(rx_data8), 32'd0);
        check("rst_rd_timeout", 32'(rd_to8), 32'd0);
        check("rst_addr_done", 32'(dut8.rd_addr_done), 32'd0);
        check("rst_rx_data16", 32'(rx_data16), 32'd0);
        rst_n = 1'b1; ss8 = 1'b1; ss16 = 1'b1; mosi = 1'b0;
        step();

        foreach (vecs[i]) begin
            send(vecs[i].mode, {8'h00, vecs[i].frame}, 10, 10, 1'b0);
            check("addr_done", 32'(dut8.rd_addr_done), 32'(vecs[i].exp_addr_done));
            seen_m = 1'b0;
            if (vecs[i].tx_delay >= 0) begin
                repeat (vecs[i].tx_delay) begin
                    seen_m |= miso8;
                    step();
                end
                check("miso_wait", 32'(seen_m), 32'd0);
                tx8 = vecs[i].tx_byte; tx_valid = 1'b1;
                step();
                tx_valid = 1'b0;
                expect_tx8(vecs[i].tx_byte, "miso_bit");
            end else begin
                tx8 = 8'hFF; tx_valid = 1'b1;
                step();
                tx_valid = 1'b0;
                repeat (9) begin
                    seen_m |= miso8;
                    step();
                end
                check("miso_quiet", 32'(seen_m), 32'd0);
            end
            check("rx_data_hold", 32'(rx_data8), 32'(vecs[i].frame));
            deselect();
        end

        // abort a write after 5 bits, then a full frame
        send(1'b0, 18'h155, 10, 5, 1'b0);
        ss8 = 1'b1;
        step();
        check("abort_rx_valid", 32'(rx_valid8), 32'd0);
        check("abort_rx_hold", 32'(rx_data8), 32'h3E1);
        send(1'b0, 18'h1C3, 10, 10, 1'b0);
        deselect();

        // aborted mode-1 frame keeps rd_addr_done; abort in the middle of TX
        send(1'b1, 18'h2F0, 10, 10, 1'b0);
        deselect();
        send(1'b1, 18'h3AA, 10, 4, 1'b0);
        ss8 = 1'b1;
        step();
        check("abort_keeps_addr_done", 32'(dut8.rd_addr_done), 32'd1);
        send(1'b1, 18'h30F, 10, 10, 1'b0);
        check("rd_data_clears", 32'(dut8.rd_addr_done), 32'd0);
        tx8 = 8'hFF; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        repeat (3) begin
            check("tx_abort_bit", 32'(miso8), 32'd1);
            step();
        end
        ss8 = 1'b1;
        step();
        check("tx_abort_miso", 32'(miso8), 32'd0);

        // reset in the middle of a frame
        send(1'b1, 18'h2AB, 10, 10, 1'b0);
        deselect();
        send(1'b0, 18'h3FF, 10, 4, 1'b0);
        rst_n = 1'b0; ss8 = 1'b1;
        step();
        rst_n = 1'b1;
        check("midrst_rx_data", 32'(rx_data8), 32'd0);
        check("midrst_addr_done", 32'(dut8.rd_addr_done), 32'd0);
        repeat (3) step();
        send(1'b1, 18'h2CD, 10, 10, 1'b0);
        check("post_rst_read_add", 32'(dut8.rd_addr_done), 32'd1);
        deselect();

        // long wait for tx_valid
        send(1'b1, 18'h311, 10, 10, 1'b0);
`ifdef SPI_TX_TIMEOUT_EN
        begin
            int k = 0;
            while (rd_to8 !== 1'b1 && k < 200) begin
                step();
                k++;
            end
            check("timeout_cycle", 32'(k), 32'd64);
            step();
            check("timeout_pulse", 32'(rd_to8), 32'd0);
            seen_m = 1'b0;
            tx8 = 8'hFF; tx_valid = 1'b1;
            step();
            tx_valid = 1'b0;
            repeat (9) begin
                seen_m |= miso8;
                step();
            end
            check("timeout_no_tx", 32'(seen_m), 32'd0);
        end
`else
        seen_m = 1'b0;
        seen_t = 1'b0;
        repeat (70) begin
            seen_m |= miso8;
            seen_t |= rd_to8;
            step();
        end
        check("wait_miso", 32'(seen_m), 32'd0);
        check("wait_no_timeout", 32'(seen_t), 32'd0);
        tx8 = 8'h81; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        expect_tx8(8'h81, "late_tx_bit");
`endif
        deselect();

        // 16-bit payload instance
        send(1'b1, 18'h21234, 18, 18, 1'b1);
        check("w16_rx_valid_a", 32'(rx_valid16), 32'd1);
        check("w16_rx_data_a", 32'(rx_data16), 32'h21234);
        check("w16_addr_done", 32'(dut16.rd_addr_done), 32'd1);
        deselect();
        send(1'b1, 18'h30000, 18, 18, 1'b1);
        check("w16_rx_valid_b", 32'(rx_valid16), 32'd1);
        check("w16_rx_data_b", 32'(rx_data16), 32'h30000);
        tx16 = 16'hA5C3; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        check("w16_rx_valid_once", 32'(rx_valid16), 32'd0);
        for (int b = 15; b >= 0; b--) begin
            check("w16_miso_bit", 32'(miso16), 32'(tx16[b]));
            step();
        end
        check("w16_miso_end", 32'(miso16), 32'd0);
        check("w16_rd_timeout", 32'(rd_to16), 32'd0);
        deselect();

        step();
        check("rx_pending", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
